// File: rtl/htif_tohost_responder_pkg.sv
// HTIF responder shared types: default register addresses, exit-status FSM states, pass code.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package htif_pkg;

    localparam logic [31:0] TOHOST_ADDR_DEF   = 32'h0000_1000;
    localparam logic [31:0] FROMHOST_ADDR_DEF = 32'h0000_1040;
    localparam logic [31:0] CONSOLE_ADDR_DEF  = 32'h0000_1080;
    localparam logic [31:0] TIMEOUT_DEF       = 32'd5000;
    localparam logic [31:0] PASS_CODE         = 32'h1;

    typedef enum logic [1:0] {
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } htif_state_e;

    // An odd tohost value ends the test; 1 means pass, anything else carries the failing test number.
    function automatic logic is_exit_code(input logic [31:0] w);
        return w[0];
    endfunction

endpackage

// File: rtl/htif_tohost_responder_if.sv
// Core data bus port of the HTIF responder: request valid/ready, one-cycle response pulse.
// Latency: n/a (signal bundle).
// Backpressure: req_ready from the slave stalls the master's request.
interface htif_tohost_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/htif_tohost_responder_console_fifo.sv
// Synchronous console byte FIFO, valid/ready on both sides.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: push_ready drops when full, unless a pop in the same cycle frees a slot.
module htif_console_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign pop_valid  = (count != '0);
    assign pop_data   = mem[rd_ptr];
    // When full, pop_valid is high, so pop_ready alone guarantees a slot frees this cycle.
    assign push_ready = (count != (AW+1)'(DEPTH)) || pop_ready;
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop_valid && pop_ready;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/htif_tohost_responder.sv
// HTIF tohost/fromhost bus responder: decodes the test exit write into done/pass/fail, plus a watchdog.
// Latency: response and status update one cycle after request acceptance. Optional console FIFO under HTIF_CONSOLE_EN.
// Backpressure: req_ready is high except for a console write while the console FIFO is full.
module htif_tohost_responder
    import htif_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR   = TOHOST_ADDR_DEF,
    parameter logic [31:0] FROMHOST_ADDR = FROMHOST_ADDR_DEF,
    parameter logic [31:0] CONSOLE_ADDR  = CONSOLE_ADDR_DEF,
    parameter logic [31:0] TIMEOUT       = TIMEOUT_DEF,
    parameter int          CON_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    htif_tohost_responder_if.slave        bus,
    output logic                          done,
    output logic                          pass,
    output logic [30:0]                   fail_code,
    output logic                          timeout,
    output logic                          con_valid,
    input  logic                          con_ready,
    output logic [7:0]                    con_data
);
    htif_state_e state_q, state_d;
    logic [31:0] tohost_q, tohost_d;
    logic [31:0] fromhost_q;
    logic [31:0] cycle_q;
    logic [30:0] fail_code_q, fail_code_d;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] rdata_mux;
    logic        acc;
    logic        is_con;
    logic        tohost_wr;
    logic        fromhost_wr;
    logic        wd_expire;

    assign is_con      = (bus.req_addr == CONSOLE_ADDR);
    assign acc         = bus.req_valid && bus.req_ready;
    assign tohost_wr   = acc && bus.req_we && (bus.req_addr == TOHOST_ADDR);
    assign fromhost_wr = acc && bus.req_we && (bus.req_addr == FROMHOST_ADDR);
    assign wd_expire   = (TIMEOUT != 32'd0) && (cycle_q == TIMEOUT - 32'd1);

`ifdef HTIF_CONSOLE_EN
    logic con_push_ready;

    assign bus.req_ready = !(bus.req_we && is_con) || con_push_ready;

    htif_console_fifo #(
        .DEPTH (CON_DEPTH),
        .W     (8)
    ) u_console_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (acc && bus.req_we && is_con),
        .push_ready (con_push_ready),
        .push_data  (bus.req_wdata[7:0]),
        .pop_valid  (con_valid),
        .pop_ready  (con_ready),
        .pop_data   (con_data)
    );
`else
    logic [2:0] unused_con;

    assign bus.req_ready = 1'b1;
    assign con_valid     = 1'b0;
    assign con_data      = 8'h00;
    assign unused_con    = {con_ready, is_con, CON_DEPTH[0]};
`endif

    always_comb begin
        state_d     = state_q;
        tohost_d    = tohost_q;
        fail_code_d = fail_code_q;
        if (state_q == S_RUN) begin
            if (tohost_wr && (bus.req_wdata != 32'd0)) begin
                tohost_d = bus.req_wdata;
                if (bus.req_wdata == PASS_CODE) begin
                    state_d = S_PASS;
                end else if (is_exit_code(bus.req_wdata)) begin
                    state_d     = S_FAIL;
                    fail_code_d = bus.req_wdata[31:1];
                end
            end
            // An exit write in the expiry cycle has already moved state_d, so it takes priority.
            if ((state_d == S_RUN) && wd_expire) begin
                state_d = S_TIMEOUT;
            end
        end
    end

    always_comb begin
        rdata_mux = 32'd0;
        if (bus.req_addr == TOHOST_ADDR) begin
            rdata_mux = tohost_q;
        end else if (bus.req_addr == FROMHOST_ADDR) begin
            rdata_mux = fromhost_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_RUN;
            tohost_q     <= 32'd0;
            fromhost_q   <= 32'd0;
            cycle_q      <= 32'd0;
            fail_code_q  <= 31'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            tohost_q     <= tohost_d;
            fail_code_q  <= fail_code_d;
            resp_valid_q <= acc;
            resp_rdata_q <= (acc && !bus.req_we) ? rdata_mux : 32'd0;
            if (fromhost_wr) begin
                fromhost_q <= bus.req_wdata;
            end
            if ((state_q == S_RUN) && (cycle_q != 32'hFFFF_FFFF)) begin
                cycle_q <= cycle_q + 32'd1;
            end
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign done           = (state_q == S_PASS) || (state_q == S_FAIL);
    assign pass           = (state_q == S_PASS);
    assign timeout        = (state_q == S_TIMEOUT);
    assign fail_code      = fail_code_q;
endmodule
